// File: rtl/keyboard_pkg.sv
// keyboard_pkg: key code constants, operator encoding and parser FSM states
// shared by the keyboard token parser and its test bench.
package keyboard_pkg;

  localparam int unsigned KEY_DIGIT_MAX = 9;
  localparam int unsigned KEY_OP_FIRST  = 10;
  localparam int unsigned KEY_OP_LAST   = 13;
  localparam int unsigned KEY_ENTER     = 14;
  localparam int unsigned KEY_CLEAR     = 15;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    MOD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } parser_state_t;

endpackage

// File: rtl/decimal_accumulator.sv
// decimal_accumulator: saturating decimal-to-binary operand accumulator.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear_all_i       clear acc, digit count and sticky overflow
//   clear_entry_i     clear acc and digit count only (overflow kept)
//   load_i, digit_i   append one decimal digit (ignored past MAX_DIGITS)
//   acc_o             current accumulated value
//   cnt_zero_o        no digit accepted yet for this operand
//   ovf_o             sticky saturation flag
module decimal_accumulator #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_all_i,
  input  logic              clear_entry_i,
  input  logic              load_i,
  input  logic [3:0]        digit_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              cnt_zero_o,
  output logic              ovf_o
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned EXT_W = DATA_W + 4;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [EXT_W-1:0]  sum;
  logic              sat;

  // acc*10+9 always fits in DATA_W+4 bits, so any set high nibble means saturation.
  always_comb begin
    sum = EXT_W'(acc_q) * EXT_W'(10) + EXT_W'(digit_i);
    sat = |sum[EXT_W-1:DATA_W];
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_all_i) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (clear_entry_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i && (cnt_q < CNT_W'(MAX_DIGITS))) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (sat) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o      = acc_q;
  assign cnt_zero_o = (cnt_q == '0);
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/keyboard_token_parser.sv
// keyboard_token_parser: assembles "A op B enter" calculator tokens from a
// stream of decoded key codes and hands them to the ALU via valid/ready.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   key_code, key_valid       decoded key strobe (dropped while key_ready low)
//   key_ready                 low only while a token is being presented
//   entry_value               live operand being typed (0 while presenting)
//   operand_a/b, op, overflow finished token fields, held until overwritten
//   out_valid, out_ready      token handshake towards the ALU
module keyboard_token_parser
  import keyboard_pkg::*;
#(
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [DATA_W-1:0] entry_value,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [1:0]        op,
  output logic              overflow,
  output logic              out_valid,
  input  logic              out_ready
);

  parser_state_t     state_q, state_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  op_t               op_q, op_d;
  logic              ovf_out_q, ovf_out_d;

  logic [DATA_W-1:0] acc;
  logic              cnt_zero, acc_ovf;
  logic              acc_load, acc_clr_all, acc_clr_entry;

  logic              accept;
  logic [31:0]       code;
  logic              is_digit, is_op, is_enter, is_clear;

  assign accept   = key_valid && key_ready;
  assign code     = 32'(key_code);
  assign is_digit = (code <= KEY_DIGIT_MAX);
  assign is_op    = (code >= KEY_OP_FIRST) && (code <= KEY_OP_LAST);
  assign is_enter = (code == KEY_ENTER);
  assign is_clear = (code == KEY_CLEAR);

  decimal_accumulator #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clk           (clk),
    .rst           (rst),
    .clear_all_i   (acc_clr_all),
    .clear_entry_i (acc_clr_entry),
    .load_i        (acc_load),
    .digit_i       (4'(code)),
    .acc_o         (acc),
    .cnt_zero_o    (cnt_zero),
    .ovf_o         (acc_ovf)
  );

  always_comb begin
    state_d       = state_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    op_d          = op_q;
    ovf_out_d     = ovf_out_q;
    acc_load      = 1'b0;
    acc_clr_all   = 1'b0;
    acc_clr_entry = 1'b0;
    unique case (state_q)
      S_A, S_B: begin
        if (accept) begin
          if (is_digit) begin
            acc_load = 1'b1;
          end else if (is_clear) begin
            acc_clr_all = 1'b1;
            opa_d       = '0;
            opb_d       = '0;
            op_d        = ADD;
            ovf_out_d   = 1'b0;
            state_d     = S_A;
          end else if (is_op && state_q == S_A && !cnt_zero) begin
            opa_d         = acc;
            op_d          = op_t'(2'(code - KEY_OP_FIRST));
            acc_clr_entry = 1'b1;
            state_d       = S_B;
          end else if (is_op && state_q == S_B && cnt_zero) begin
            op_d = op_t'(2'(code - KEY_OP_FIRST));
          end else if (is_enter && state_q == S_B && !cnt_zero) begin
            opb_d     = acc;
            ovf_out_d = acc_ovf;
            state_d   = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_clr_all = 1'b1;
          state_d     = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_A;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= ADD;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign key_ready   = (state_q != S_OUT);
  assign out_valid   = (state_q == S_OUT);
  assign entry_value = (state_q == S_OUT) ? '0 : acc;
  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign op          = op_q;
  assign overflow    = ovf_out_q;

endmodule
